// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 microcode sequencer: control-store word
// layout, sequencer states and the reserved microcode addresses.
package mic1_pkg;

    // Control-store word, MSB first: NEXT_ADDRESS[35:27] JMPC[26] JAMN[25] JAMZ[24] ALU[23:16] MIR[15:0]
    typedef struct packed {
        logic [8:0]  next_address;
        logic        jmpc;
        logic        jamn;
        logic        jamz;
        logic [7:0]  alu;
        logic [15:0] mir;
    } cs_word_t;

    // Memory request bits inside the MIR field
    localparam int MEM_WR_BIT    = 6;
    localparam int MEM_RD_BIT    = 5;
    localparam int MEM_FETCH_BIT = 4;

    localparam logic [8:0] HALT_ADDR  = 9'h1FF;
    localparam logic [8:0] RESET_ADDR = 9'h000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mic1_next_addr.sv
// Next-MPC computation: conditional high-bit jump on ALU flags and the
// JMPC dispatch that ORs the MBR byte into the low address bits.
module mic1_next_addr (
    input  logic [8:0] na_i,
    input  logic       jmpc_i,
    input  logic       jamn_i,
    input  logic       jamz_i,
    input  logic       alu_n_i,
    input  logic       alu_z_i,
    input  logic [7:0] mbr_i,
    output logic [8:0] next_mpc_o
);

    assign next_mpc_o[8]   = na_i[8] | (jamn_i & alu_n_i) | (jamz_i & alu_z_i);
    assign next_mpc_o[7:0] = jmpc_i ? (na_i[7:0] | mbr_i) : na_i[7:0];

endmodule

// File: rtl/mic1_sequencer.sv
// MIC-1 microprogram sequencer: FETCH/EXEC/HALT control around a registered
// control store, with memory-wait stalls and activity counters.
module mic1_sequencer
    import mic1_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [8:0]  cs_addr,
    input  logic [35:0] cs_data,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic [7:0]  mbr_in,
    input  logic        mem_ready,
    output logic [15:0] MIR,
    output logic [7:0]  alu_ctrl,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_fetch,
    output logic        stall,
    output logic        halted,
    output logic [31:0] uinst_count,
    output logic [15:0] stall_count
);

    seq_state_e  state_q, state_d;
    logic [8:0]  mpc_q, mpc_d;
    logic [31:0] uc_q, uc_d;
    logic [15:0] sc_q, sc_d;

    cs_word_t    word;
    logic [8:0]  next_mpc;
    logic        in_exec;
    logic        mem_req;
    logic        stall_w;
    logic        complete;

    assign word     = cs_word_t'(cs_data);
    assign in_exec  = (state_q == ST_EXEC);
    assign mem_req  = word.mir[MEM_WR_BIT] | word.mir[MEM_RD_BIT] | word.mir[MEM_FETCH_BIT];
    assign stall_w  = in_exec & mem_req & ~mem_ready;
    assign complete = in_exec & ~stall_w;

    mic1_next_addr u_next_addr (
        .na_i       (word.next_address),
        .jmpc_i     (word.jmpc),
        .jamn_i     (word.jamn),
        .jamz_i     (word.jamz),
        .alu_n_i    (alu_n),
        .alu_z_i    (alu_z),
        .mbr_i      (mbr_in),
        .next_mpc_o (next_mpc)
    );

    always_comb begin
        state_d = state_q;
        mpc_d   = mpc_q;
        uc_d    = uc_q;
        sc_d    = sc_q;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (complete) begin
                    mpc_d   = next_mpc;
                    uc_d    = uc_q + 32'd1;
                    state_d = (next_mpc == HALT_ADDR) ? ST_HALT : ST_FETCH;
                end else begin
                    sc_d = sat_inc16(sc_q);
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            mpc_q   <= RESET_ADDR;
            uc_q    <= 32'd0;
            sc_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            uc_q    <= uc_d;
            sc_q    <= sc_d;
        end
    end

    // Memory requests stay up through a stall; datapath controls only on completion
    assign mem_wr      = in_exec & word.mir[MEM_WR_BIT];
    assign mem_rd      = in_exec & word.mir[MEM_RD_BIT];
    assign mem_fetch   = in_exec & word.mir[MEM_FETCH_BIT];
    assign MIR         = complete ? word.mir : 16'd0;
    assign alu_ctrl    = complete ? word.alu : 8'd0;
    assign stall       = stall_w;
    assign halted      = (state_q == ST_HALT);
    assign cs_addr     = mpc_q;
    assign uinst_count = uc_q;
    assign stall_count = sc_q;

endmodule

// File: tb/tb_mic1_sequencer.sv
// Directed bench for mic1_sequencer: stimulus pushes per-cycle expectations
// into a scoreboard queue, a negedge monitor pops and compares them.
module tb_mic1_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  cs_addr;
    logic [35:0] cs_data = '0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic [7:0]  mbr_in = 8'd0;
    logic        mem_ready = 1'b1;
    logic [15:0] MIR;
    logic [7:0]  alu_ctrl;
    logic        mem_rd, mem_wr, mem_fetch, stall, halted;
    logic [31:0] uinst_count;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        int          cyc;
        logic [8:0]  addr;
        logic [15:0] mir;
        logic [7:0]  alu;
        logic [2:0]  mem;   // {wr, rd, fetch}
        logic        stl;
        logic        hlt;
        logic [31:0] uc;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];

    logic [35:0] rom [0:511];

    mic1_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .cs_addr     (cs_addr),
        .cs_data     (cs_data),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .mbr_in      (mbr_in),
        .mem_ready   (mem_ready),
        .MIR         (MIR),
        .alu_ctrl    (alu_ctrl),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_fetch   (mem_fetch),
        .stall       (stall),
        .halted      (halted),
        .uinst_count (uinst_count),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    // Registered control store
    always @(posedge clock) cs_data <= rom[cs_addr];
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [35:0] w(input logic [8:0] na, input logic jmpc, input logic jamn,
                                      input logic jamz, input logic [7:0] alu, input logic [15:0] mir);
        return {na, jmpc, jamn, jamz, alu, mir};
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %0h, required %0h", nm, fld, act, req);
        end
    endtask

    // Push the expectation for the current cycle, then advance one clock
    task automatic step(input string nm, input logic [8:0] addr, input logic [15:0] mir,
                        input logic [7:0] alu, input logic [2:0] mem, input logic stl,
                        input logic hlt, input logic [31:0] uc, input logic [15:0] sc);
        exp_t e;
        e.name = nm; e.cyc = cyc; e.addr = addr; e.mir = mir; e.alu = alu;
        e.mem = mem; e.stl = stl; e.hlt = hlt; e.uc = uc; e.sc = sc;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s.cycle: got %0d, required %0d", e.name, cyc, e.cyc);
            end else begin
                chk(e.name, "cs_addr",     32'(cs_addr),     32'(e.addr));
                chk(e.name, "MIR",         32'(MIR),         32'(e.mir));
                chk(e.name, "alu_ctrl",    32'(alu_ctrl),    32'(e.alu));
                chk(e.name, "mem",         32'({mem_wr, mem_rd, mem_fetch}), 32'(e.mem));
                chk(e.name, "stall",       32'(stall),       32'(e.stl));
                chk(e.name, "halted",      32'(halted),      32'(e.hlt));
                chk(e.name, "uinst_count", uinst_count,      e.uc);
                chk(e.name, "stall_count", 32'(stall_count), 32'(e.sc));
                $display("txn cyc=%0d %s addr=%0h MIR=%0h alu=%0h mem=%b stall=%b halted=%b uc=%0d sc=%0d",
                         cyc, e.name, cs_addr, MIR, alu_ctrl, {mem_wr, mem_rd, mem_fetch},
                         stall, halted, uinst_count, stall_count);
            end
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = '0;
        rom[9'h000] = w(9'h005, 1'b0, 1'b0, 1'b0, 8'h3C, 16'h8003);
        rom[9'h005] = w(9'h012, 1'b0, 1'b0, 1'b1, 8'h11, 16'h4001);
        rom[9'h112] = w(9'h100, 1'b0, 1'b0, 1'b0, 8'h22, 16'h0102);
        rom[9'h100] = w(9'h100, 1'b1, 1'b0, 1'b0, 8'h33, 16'h0204);
        rom[9'h15A] = w(9'h012, 1'b0, 1'b0, 1'b1, 8'h44, 16'h0408);
        rom[9'h012] = w(9'h1FF, 1'b0, 1'b1, 1'b0, 8'h55, 16'h0800);

        // Reset, then walk plain, JAMZ, JMPC and halting microinstructions
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("rst",       9'h000, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 0, 0);
        step("exec000",   9'h000, 16'h8003, 8'h3C, 3'b000, 1'b0, 1'b0, 0, 0);
        step("fetch005",  9'h005, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 1, 0);
        alu_z = 1'b1;
        step("exec005",   9'h005, 16'h4001, 8'h11, 3'b000, 1'b0, 1'b0, 1, 0);
        alu_z = 1'b0;
        step("fetch112",  9'h112, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 2, 0);
        step("exec112",   9'h112, 16'h0102, 8'h22, 3'b000, 1'b0, 1'b0, 2, 0);
        step("fetch100",  9'h100, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 3, 0);
        mbr_in = 8'h5A;
        step("exec100",   9'h100, 16'h0204, 8'h33, 3'b000, 1'b0, 1'b0, 3, 0);
        mbr_in = 8'h00;
        step("fetch15A",  9'h15A, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 4, 0);
        step("exec15A",   9'h15A, 16'h0408, 8'h44, 3'b000, 1'b0, 1'b0, 4, 0);
        step("fetch012",  9'h012, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 5, 0);
        step("exec012",   9'h012, 16'h0800, 8'h55, 3'b000, 1'b0, 1'b0, 5, 0);
        step("halt1",     9'h1FF, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b1, 6, 0);
        alu_z = 1'b1;
        mem_ready = 1'b0;
        step("halt2",     9'h1FF, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b1, 6, 0);
        alu_z = 1'b0;
        mem_ready = 1'b1;

        // New microprogram: a read and a write+fetch that wait on memory
        rom[9'h000] = w(9'h020, 1'b0, 1'b0, 1'b0, 8'h66, 16'h8020);
        rom[9'h020] = w(9'h030, 1'b0, 1'b0, 1'b0, 8'h77, 16'h0050);
        reset = 1'b1;
        step("halt_rst",  9'h1FF, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b1, 6, 0);
        reset = 1'b0;
        step("rst_fetch", 9'h000, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 0, 0);
        mem_ready = 1'b0;
        step("stall1",    9'h000, 16'h0000, 8'h00, 3'b010, 1'b1, 1'b0, 0, 0);
        step("stall2",    9'h000, 16'h0000, 8'h00, 3'b010, 1'b1, 1'b0, 0, 1);
        step("stall3",    9'h000, 16'h0000, 8'h00, 3'b010, 1'b1, 1'b0, 0, 2);
        mem_ready = 1'b1;
        step("rd_done",   9'h000, 16'h8020, 8'h66, 3'b010, 1'b0, 1'b0, 0, 3);
        step("fetch020",  9'h020, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 1, 3);
        mem_ready = 1'b0;
        step("wf_stall1", 9'h020, 16'h0000, 8'h00, 3'b101, 1'b1, 1'b0, 1, 3);
        reset = 1'b1;
        step("wf_stall2", 9'h020, 16'h0000, 8'h00, 3'b101, 1'b1, 1'b0, 1, 4);
        reset = 1'b0;
        mem_ready = 1'b1;
        step("midrst",    9'h000, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 0, 0);
        step("exec000b",  9'h000, 16'h8020, 8'h66, 3'b010, 1'b0, 1'b0, 0, 0);
        step("fetch020b", 9'h020, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0, 1, 0);

        @(posedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic1_sequencer.md
MIC1_SEQUENCER -- requirements
Module: mic1_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high.
REQ-003 SHALL have port cs_addr, output, 9, control-store address (= MPC).
REQ-004 SHALL have port cs_data, input, 36, control-store word; valid one cycle after cs_addr (registered ROM).
REQ-005 SHALL have port alu_n, alu_z, input, 1 each, ALU flags of current datapath cycle.
REQ-006 SHALL have port mbr_in, input, 8, MBR low byte for JMPC.
REQ-007 SHALL have port mem_ready, input, 1, memory can complete requested op this cycle.
REQ-008 SHALL have port MIR, output, 16, datapath word: [15:7] C enables H..MAR, [6] write, [5] read, [4] fetch, [3:0] B select.
REQ-009 SHALL have port alu_ctrl, output, 8, ALU/shifter control.
REQ-010 SHALL have port mem_rd, mem_wr, mem_fetch, output, 1 each, memory requests.
REQ-011 SHALL have port stall, output, 1, EXEC cycle suppressed by memory wait.
REQ-012 SHALL have port halted, output, 1, sequencer in HALT.
REQ-013 SHALL have port uinst_count, output, 32, completed microinstructions; stall_count, output, 16, stall cycles.

Function
REQ-014 SHALL use word fields: NEXT_ADDRESS [35:27], JMPC [26], JAMN [25], JAMZ [24], ALU [23:16], MIR [15:0].
REQ-015 SHALL implement states FETCH, EXEC, HALT; FETCH->EXEC always; EXEC->FETCH on completion; EXEC->HALT when computed next MPC = 0x1FF; HALT exits only on reset.
REQ-016 SHALL drive MIR = 0, alu_ctrl = 0, mem_* = 0 in FETCH and HALT.
REQ-017 SHALL in EXEC drive mem_wr/mem_rd/mem_fetch = cs_data[6]/[5]/[4].
REQ-018 SHALL in EXEC, when any of cs_data[6:4] set and mem_ready = 0, drive MIR = 0, alu_ctrl = 0, stall = 1, hold mem_* asserted, remain in EXEC, hold MPC.
REQ-019 SHALL otherwise in EXEC drive MIR = cs_data[15:0], alu_ctrl = cs_data[23:16], stall = 0 (completion cycle).
REQ-020 SHALL on completion compute next MPC[8] = NA[8] | (JAMN & alu_n) | (JAMZ & alu_z), sampled at that edge.
REQ-021 SHALL on completion compute next MPC[7:0] = JMPC ? (NA[7:0] | mbr_in) : NA[7:0].
REQ-022 SHALL keep cs_addr = MPC stable through EXEC including stall cycles.
REQ-023 SHALL increment uinst_count by 1 per completion, wrapping modulo 2^32.
REQ-024 SHALL increment stall_count by 1 per stall cycle, saturating at 0xFFFF.
REQ-025 SHALL count the completion that enters HALT; no counting in HALT.

Reset
REQ-026 SHALL on reset set state FETCH, MPC 0, uinst_count 0, stall_count 0, halted 0.
REQ-027 SHALL let reset override all, including mid-stall and HALT; outputs zero in the cycle after reset.

Structure
REQ-028 SHALL place field bit positions, state enum, HALT_ADDR (0x1FF), RESET_ADDR (0x000) in shared package mic1_pkg.
REQ-029 SHALL isolate next-address logic (REQ-020/021) in combinational sub-module mic1_next_addr.

Verification
REQ-030 SHALL cover: reset, word at 0x000 NA=0x005 no mem -> MIR valid cycle 2, cs_addr=0x005 cycle 3, uinst_count=1.
REQ-031 SHALL cover: JAMZ=1, NA=0x012, alu_z=1 -> next MPC 0x112; alu_z=0 -> 0x012.
REQ-032 SHALL cover: JMPC=1, NA=0x100, mbr_in=0x5A -> next MPC 0x15A.
REQ-033 SHALL cover: read (bit5) with mem_ready low 3 cycles -> MIR=0, stall=1 x3, mem_rd held, stall_count=3, MPC unchanged, then completes.
REQ-034 SHALL cover: NA=0x1FF -> halted=1, MIR=0 thereafter; reset then -> MPC 0, halted 0.
REQ-035 SHALL cover: reset asserted mid-stall -> FETCH at 0x000, counters 0, mem_* deasserted.
